// File: rtl/d5m_frame_gen.sv
// D5M camera test-pattern source: generates ifval/ilval/idata frame timing
// with selectable Bayer/ramp/constant/checker patterns and frame bookkeeping.
module d5m_frame_gen #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 8,
    parameter int H_BLANK    = 4,
    parameter int V_BLANK    = 6,
    parameter int FV_LEAD    = 2,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic [1:0]            pattern,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic                  ifval,
    output logic                  ilval,
    output logic [DATA_WIDTH-1:0] idata,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, VBLANK} state_t;

    localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);
    localparam logic [15:0] X_LAST    = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST    = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BLANK - 1);
    localparam logic [DATA_WIDTH-1:0] G_VAL = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] B_VAL = DATA_WIDTH'(1) << (DATA_WIDTH - 4);

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             x_q, x_d;
    logic [15:0]             y_q, y_d;
    logic [1:0]              pat_q, pat_d;
    logic [DATA_WIDTH-1:0]   cv_q, cv_d;
    logic [DATA_WIDTH-1:0]   pix;
    logic                    start_d, done_d;
    logic [15:0]             frame_cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        x_d     = x_q;
        y_d     = y_q;
        pat_d   = pat_q;
        cv_d    = cv_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = LEAD;
                    pat_d   = pattern;
                    cv_d    = const_value;
                    start_d = 1'b1;
                end
            end
            LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = LINE;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            LINE: begin
                cnt_d = '0;
                if (x_q == X_LAST) state_d = HBLANK;
                else               x_d     = x_q + 16'd1;
            end
            HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    x_d   = '0;
                    if (y_q == Y_LAST) begin
                        state_d = VBLANK;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LINE;
                        y_d     = y_q + 16'd1;
                    end
                end
            end
            VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = LEAD;
                        pat_d   = pattern;
                        cv_d    = const_value;
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel is computed from next-cycle coordinates so idata registers alongside ilval.
    always_comb begin
        pix = '0;
        unique case (pat_d)
            2'd0: pix = DATA_WIDTH'(32'(x_d) + 32'(y_d));
            2'd1: begin
                if (!y_d[0]) pix = x_d[0] ? G_VAL : '1;
                else         pix = x_d[0] ? B_VAL : G_VAL;
            end
            2'd2: pix = cv_d;
            default: pix = (x_d[2] ^ y_d[2]) ? '1 : '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pat_q       <= '0;
            cv_q        <= '0;
            ifval       <= 1'b0;
            ilval       <= 1'b0;
            idata       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pat_q       <= pat_d;
            cv_q        <= cv_d;
            ifval       <= (state_d == LEAD) || (state_d == LINE) || (state_d == HBLANK);
            ilval       <= (state_d == LINE);
            idata       <= (state_d == LINE) ? pix : '0;
            frame_start <= start_d;
            frame_done  <= done_d;
            busy        <= (state_d != IDLE);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)    frame_cnt_q <= '0;
        else if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_d5m_frame_gen.sv
// Self-checking bench for d5m_frame_gen: frame timing and pixel patterns are
// predicted from the frame-relative cycle index with plain arithmetic.
module tb_d5m_frame_gen;

    localparam int W      = 16;
    localparam int H      = 8;
    localparam int HB     = 4;
    localparam int VB     = 6;
    localparam int LEADC  = 2;
    localparam int DW     = 12;
    localparam int LP     = W + HB;
    localparam int PERIOD = LEADC + H * LP + VB;
    localparam int FD_T   = LEADC + H * LP;

    typedef logic [DW+4:0] obs_t;

    logic          ACLK;
    logic          ARESETN;
    logic          enable;
    logic [1:0]    pattern;
    logic [DW-1:0] const_value;
    logic          ifval;
    logic          ilval;
    logic [DW-1:0] idata;
    logic          frame_start;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    d5m_frame_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .H_BLANK   (HB),
        .V_BLANK   (VB),
        .FV_LEAD   (LEADC),
        .DATA_WIDTH(DW)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .enable     (enable),
        .pattern    (pattern),
        .const_value(const_value),
        .ifval      (ifval),
        .ilval      (ilval),
        .idata      (idata),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .busy       (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [DW-1:0] pix(int pat, logic [DW-1:0] cv, int x, int y);
        logic [DW-1:0] ones;
        ones = '1;
        case (pat)
            0: return DW'((x + y) % (1 << DW));
            1: begin
                if (y % 2 == 0) return (x % 2 == 0) ? ones : DW'(1 << (DW - 1));
                else            return (x % 2 == 0) ? DW'(1 << (DW - 1)) : DW'(1 << (DW - 4));
            end
            2: return cv;
            default: return (((x / 4) % 2) != ((y / 4) % 2)) ? ones : '0;
        endcase
    endfunction

    // {busy, ifval, ilval, frame_start, frame_done, idata} for cycle t of a frame
    function automatic obs_t model(int t, int pat, logic [DW-1:0] cv);
        logic ifv, ilv, fs, fd;
        logic [DW-1:0] d;
        int u;
        ifv = 1'b1; ilv = 1'b0; fd = 1'b0; d = '0;
        fs  = (t == 0);
        if (t >= LEADC) begin
            u = t - LEADC;
            if (u < H * LP) begin
                if (u % LP < W) begin
                    ilv = 1'b1;
                    d   = pix(pat, cv, u % LP, u / LP);
                end
            end else begin
                ifv = 1'b0;
                fd  = (u == H * LP);
            end
        end
        return {1'b1, ifv, ilv, fs, fd, d};
    endfunction

    function automatic obs_t obs();
        return {busy, ifval, ilval, frame_start, frame_done, idata};
    endfunction

    task automatic start_run(input logic [1:0] pat, input logic [DW-1:0] cv);
        ARESETN     = 1'b0;
        enable      = 1'b1;
        pattern     = pat;
        const_value = cv;
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; enable = 1'b1; pattern = 2'd0; const_value = '0;
        repeat (3) @(negedge ACLK);
        tests_run++;
        if (obs() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h expected %h", obs(), obs_t'(0));
        end
        tests_run++;
        if (frame_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count got %h expected 0000", frame_count);
        end
    endtask

    task automatic test_pattern0();
        obs_t e;
        int lv_cnt = 0;
        int fd_at  = -1;
        start_run(2'd0, '0);
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge ACLK);
            e = model(t, 0, '0);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL pat0 t=%0d got %h expected %h", t, obs(), e);
            end
            if (ilval) lv_cnt++;
            if (frame_done) fd_at = t;
        end
        tests_run++;
        if (lv_cnt !== W * H) begin
            tests_failed++;
            $display("FAIL pat0_active_cycles got %0d expected %0d", lv_cnt, W * H);
        end
        tests_run++;
        if (fd_at !== FD_T) begin
            tests_failed++;
            $display("FAIL pat0_done_offset got %0d expected %0d", fd_at, FD_T);
        end
        tests_run++;
        if (frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL pat0_count got %h expected 0001", frame_count);
        end
        @(negedge ACLK);
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL pat0_restart got %b expected 1", frame_start);
        end
    endtask

    task automatic test_bayer();
        obs_t e;
        logic [DW-1:0] cv;
        cv = DW'($urandom);
        start_run(2'd1, cv);
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge ACLK);
            e = model(t, 1, cv);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL bayer t=%0d got %h expected %h", t, obs(), e);
            end
        end
    endtask

    task automatic test_const();
        obs_t e;
        logic [DW-1:0] cv;
        start_run(2'd2, 12'hABC);
        for (int t = 0; t < 2 * PERIOD; t++) begin
            @(negedge ACLK);
            cv = (t < PERIOD) ? 12'hABC : 12'h123;
            e  = model(t % PERIOD, 2, cv);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL const t=%0d got %h expected %h", t, obs(), e);
            end
            if (t == 50) const_value = 12'h123;
        end
        tests_run++;
        if (frame_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL const_count got %h expected 0002", frame_count);
        end
    endtask

    task automatic test_enable_drop();
        obs_t e;
        int pat, t_drop;
        logic [DW-1:0] cv;
        pat    = int'($urandom_range(0, 3));
        cv     = DW'($urandom);
        t_drop = LEADC + 3 * LP + int'($urandom_range(0, W - 1));
        start_run(2'(pat), cv);
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge ACLK);
            e = model(t, pat, cv);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL drop t=%0d got %h expected %h", t, obs(), e);
            end
            if (t == t_drop) enable = 1'b0;
        end
        tests_run++;
        if (frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL drop_count got %h expected 0001", frame_count);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            tests_run++;
            if (obs() !== '0) begin
                tests_failed++;
                $display("FAIL drop_idle i=%0d got %h expected %h", i, obs(), obs_t'(0));
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e;
        start_run(2'd0, '0);
        for (int t = 0; t < PERIOD + LEADC + 5; t++) begin
            @(negedge ACLK);
            e = model(t % PERIOD, 0, '0);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL arst_pre t=%0d got %h expected %h", t, obs(), e);
            end
        end
        tests_run++;
        if (frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL arst_pre_count got %h expected 0001", frame_count);
        end
        #2 ARESETN = 1'b0;
        #1;
        tests_run++;
        if (obs() !== '0) begin
            tests_failed++;
            $display("FAIL arst_immediate got %h expected %h", obs(), obs_t'(0));
        end
        tests_run++;
        if (frame_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL arst_count got %h expected 0000", frame_count);
        end
        @(negedge ACLK);
        tests_run++;
        if (obs() !== '0) begin
            tests_failed++;
            $display("FAIL arst_held got %h expected %h", obs(), obs_t'(0));
        end
        ARESETN = 1'b1;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge ACLK);
            e = model(t, 0, '0);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL arst_post t=%0d got %h expected %h", t, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        int cur_pat, nxt_pat, t_chg;
        logic [DW-1:0] cur_cv, nxt_cv;
        cur_pat = int'($urandom_range(0, 3));
        cur_cv  = DW'($urandom);
        start_run(2'(cur_pat), cur_cv);
        for (int f = 0; f < 3; f++) begin
            nxt_pat = int'($urandom_range(0, 3));
            nxt_cv  = DW'($urandom);
            t_chg   = int'($urandom_range(1, PERIOD - 1));
            for (int t = 0; t < PERIOD; t++) begin
                @(negedge ACLK);
                e = model(t, cur_pat, cur_cv);
                tests_run++;
                if (obs() !== e) begin
                    tests_failed++;
                    $display("FAIL b2b f=%0d t=%0d pat=%0d got %h expected %h", f, t, cur_pat, obs(), e);
                end
                if (t == t_chg) begin
                    pattern     = 2'(nxt_pat);
                    const_value = nxt_cv;
                end
            end
            tests_run++;
            if (frame_count !== 16'(f + 1)) begin
                tests_failed++;
                $display("FAIL b2b_count f=%0d got %h expected %h", f, frame_count, 16'(f + 1));
            end
            cur_pat = nxt_pat;
            cur_cv  = nxt_cv;
        end
    endtask

    task automatic test_wrap();
        obs_t e;
        int pat;
        logic [DW-1:0] cv;
        pat = int'($urandom_range(0, 3));
        cv  = DW'($urandom);
        ARESETN = 1'b0; enable = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge ACLK);
        release dut.frame_cnt_q;
        pattern = 2'(pat); const_value = cv; enable = 1'b1;
        for (int t = 0; t <= PERIOD; t++) begin
            @(negedge ACLK);
            e = model(t % PERIOD, pat, cv);
            tests_run++;
            if (obs() !== e) begin
                tests_failed++;
                $display("FAIL wrap t=%0d got %h expected %h", t, obs(), e);
            end
            if (t == FD_T - 1) begin
                tests_run++;
                if (frame_count !== 16'hFFFF) begin
                    tests_failed++;
                    $display("FAIL wrap_before got %h expected ffff", frame_count);
                end
            end
            if (t == FD_T) begin
                tests_run++;
                if (frame_count !== 16'h0000) begin
                    tests_failed++;
                    $display("FAIL wrap_after got %h expected 0000", frame_count);
                end
            end
        end
    endtask

    initial begin
        ARESETN = 1'b0; enable = 1'b0; pattern = 2'd0; const_value = '0;
        test_reset();
        test_pattern0();
        test_bayer();
        test_const();
        test_enable_drop();
        test_async_reset();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
